// File: rtl/rom_fetch_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rom_fetch_arbiter_pkg                                            |
// | Shared bus widths, ROM tag encodings and address helpers.        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package rom_fetch_arbiter_pkg;

  localparam int c_inst_addr_w = 32;
  localparam int c_inst_w      = 32;

  typedef logic [c_inst_addr_w-1:0] inst_addr_t;
  typedef logic [c_inst_w-1:0]      inst_t;

  localparam inst_t c_zero_word    = '0;
  localparam logic  c_chip_enable  = 1'b1;
  localparam logic  c_chip_disable = 1'b0;

  // Identifies which requester owns the ROM read currently in flight.
  typedef enum logic [1:0] {
    TAG_NONE = 2'b00,
    TAG_IF   = 2'b01,
    TAG_PF   = 2'b10
  } fetch_tag_e;

  function automatic inst_addr_t word_align(input inst_addr_t addr);
    return addr & ~inst_addr_t'(3);
  endfunction

  function automatic logic same_word(input inst_addr_t a, input inst_addr_t b);
    return ((a ^ b) & ~inst_addr_t'(3)) == '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rom_fetch_arbiter_fetch_pf_buf.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_pf_buf                                                     |
// | One-entry buffer of the last prefetched word (FETCH_PF_BUF_EN).  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`ifdef FETCH_PF_BUF_EN
module fetch_pf_buf
  import rom_fetch_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       load,
  input  inst_addr_t load_addr,
  input  inst_t      load_data,
  input  inst_addr_t lookup_addr,
  output logic       hit,
  output inst_t      hit_data
);

  logic       r_valid;
  inst_addr_t r_addr;
  inst_t      r_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= c_zero_word;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_addr  <= word_align(load_addr);
      r_data  <= load_data;
    end
  end

  assign hit      = r_valid & same_word(lookup_addr, r_addr);
  assign hit_data = r_data;

endmodule
`endif
`default_nettype wire

// File: rtl/rom_fetch_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rom_fetch_arbiter                                                |
// | Shares the instruction-ROM port between IF and the prefetcher;   |
// | optional prefetch buffer under FETCH_PF_BUF_EN.                  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rom_fetch_arbiter
  import rom_fetch_arbiter_pkg::*;
#(
  parameter int unsigned PF_MAX_WAIT = 4
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_req,
  input  logic [c_inst_addr_w-1:0] if_addr,
  input  logic                     if_stall,
  output logic                     if_gnt,
  output logic                     if_rvalid,
  output logic [c_inst_w-1:0]      if_rdata,
  input  logic                     pf_req,
  input  logic [c_inst_addr_w-1:0] pf_addr,
  output logic                     pf_gnt,
  output logic                     pf_rvalid,
  output logic [c_inst_w-1:0]      pf_rdata,
  input  logic                     flush,
  output logic                     rom_ce,
  output logic [c_inst_addr_w-1:0] rom_addr,
  input  logic [c_inst_w-1:0]      rom_inst
);

  localparam logic [3:0] c_pf_max_wait = 4'(PF_MAX_WAIT);

  logic [3:0] r_wait_cnt;
  fetch_tag_e r_tag;
  logic       r_rom_ce;
  inst_addr_t r_rom_addr;
  logic       r_if_rvalid;
  inst_t      r_if_rdata;
  logic       r_pf_rvalid;
  inst_t      r_pf_rdata;

  logic       w_force_pf;
  logic       w_if_hit;
  logic       w_if_rom_gnt;
  logic       w_pf_gnt;
  logic       w_issue;
  inst_addr_t w_issue_addr;
  fetch_tag_e w_issue_tag;
  logic       w_if_return;
  logic       w_pf_return;
  logic       w_hit_return;
  inst_t      w_hit_data;

  // ---------------- prefetch buffer ----------------
`ifdef FETCH_PF_BUF_EN
  logic  w_buf_hit;
  inst_t w_buf_data;
  logic  r_hit_pend;
  inst_t r_hit_data;

  fetch_pf_buf u_pf_buf (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .load        (w_pf_return),
    .load_addr   (r_rom_addr),
    .load_data   (rom_inst),
    .lookup_addr (if_addr),
    .hit         (w_buf_hit),
    .hit_data    (w_buf_data)
  );

  // A hit never touches the ROM, so it ignores forced prefetch priority.
  assign w_if_hit = if_req & ~if_stall & ~flush & w_buf_hit;

  // Delay the buffered word one cycle so it matches the ROM path latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_pend <= 1'b0;
      r_hit_data <= c_zero_word;
    end else begin
      r_hit_pend <= w_if_hit;
      if (w_if_hit) begin
        r_hit_data <= w_buf_data;
      end
    end
  end

  assign w_hit_return = r_hit_pend & ~flush;
  assign w_hit_data   = r_hit_data;
`else
  assign w_if_hit     = 1'b0;
  assign w_hit_return = 1'b0;
  assign w_hit_data   = c_zero_word;
`endif

  // ---------------- arbitration ----------------
  assign w_force_pf   = pf_req & (r_wait_cnt == c_pf_max_wait);
  assign w_if_rom_gnt = if_req & ~if_stall & ~flush & ~w_force_pf & ~w_if_hit;
  assign w_pf_gnt     = pf_req & ~flush & ~w_if_rom_gnt;
  assign w_issue      = w_if_rom_gnt | w_pf_gnt;

  always_comb begin
    w_issue_addr = pf_addr;
    w_issue_tag  = TAG_NONE;
    if (w_if_rom_gnt) begin
      w_issue_addr = if_addr;
      w_issue_tag  = TAG_IF;
    end else if (w_pf_gnt) begin
      w_issue_tag  = TAG_PF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt <= 4'd0;
    end else if (w_pf_gnt) begin
      r_wait_cnt <= 4'd0;
    end else if (pf_req && (r_wait_cnt < c_pf_max_wait)) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  // ---------------- ROM issue ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rom_ce   <= c_chip_disable;
      r_rom_addr <= '0;
      r_tag      <= TAG_NONE;
    end else begin
      r_rom_ce <= w_issue ? c_chip_enable : c_chip_disable;
      r_tag    <= w_issue_tag;
      if (w_issue) begin
        r_rom_addr <= word_align(w_issue_addr);
      end
    end
  end

  // ---------------- response routing ----------------
  assign w_if_return = (r_tag == TAG_IF) & ~flush;
  assign w_pf_return = (r_tag == TAG_PF) & ~flush;

  // IF response is held across a stall; a flush discards it unconditionally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= c_zero_word;
    end else if (flush) begin
      r_if_rvalid <= 1'b0;
    end else if (w_if_return) begin
      r_if_rvalid <= 1'b1;
      r_if_rdata  <= rom_inst;
    end else if (w_hit_return) begin
      r_if_rvalid <= 1'b1;
      r_if_rdata  <= w_hit_data;
    end else if (!if_stall) begin
      r_if_rvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pf_rvalid <= 1'b0;
      r_pf_rdata  <= c_zero_word;
    end else begin
      r_pf_rvalid <= w_pf_return;
      if (w_pf_return) begin
        r_pf_rdata <= rom_inst;
      end
    end
  end

  assign if_gnt    = w_if_rom_gnt | w_if_hit;
  assign pf_gnt    = w_pf_gnt;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign pf_rvalid = r_pf_rvalid;
  assign pf_rdata  = r_pf_rdata;
  assign rom_ce    = r_rom_ce;
  assign rom_addr  = r_rom_addr;

endmodule
`default_nettype wire

// File: tb/tb_rom_fetch_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_rom_fetch_arbiter                                             |
// | Self-checking bench: per-scenario tasks plus response scoreboard.|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_rom_fetch_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, if_stall = 1'b0, pf_req = 1'b0, flush = 1'b0;
  logic [31:0] if_addr = '0, pf_addr = '0;
  logic        if_gnt, if_rvalid, pf_gnt, pf_rvalid, rom_ce;
  logic [31:0] if_rdata, pf_rdata, rom_addr, rom_inst;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } exp_t;

  exp_t if_q[$];
  exp_t pf_q[$];

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hC0DE_0000 + (a >> 2);
  endfunction

  assign rom_inst = rom_word(rom_addr);

  rom_fetch_arbiter #(.PF_MAX_WAIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_stall  (if_stall),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .pf_req    (pf_req),
    .pf_addr   (pf_addr),
    .pf_gnt    (pf_gnt),
    .pf_rvalid (pf_rvalid),
    .pf_rdata  (pf_rdata),
    .flush     (flush),
    .rom_ce    (rom_ce),
    .rom_addr  (rom_addr),
    .rom_inst  (rom_inst)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: expected responses due at a given cycle, plus IF hold model.
  logic        exp_if_v = 1'b0;
  logic [31:0] exp_if_d = '0;
  logic        last_stall = 1'b0, last_flush = 1'b0;

  always @(negedge clk) begin
    logic        hold;
    logic        exp_pf_v;
    logic [31:0] exp_pf_d;
    if (!rst) begin
      if_q.delete();
      pf_q.delete();
      exp_if_v   = 1'b0;
      last_stall = 1'b0;
      last_flush = 1'b0;
    end else begin
      hold = exp_if_v && last_stall && !last_flush;
      if (if_q.size() > 0 && if_q[0].due == cyc) begin
        exp_if_v = 1'b1;
        exp_if_d = if_q[0].data;
        void'(if_q.pop_front());
      end else begin
        exp_if_v = hold;
      end
      exp_pf_v = 1'b0;
      exp_pf_d = '0;
      if (pf_q.size() > 0 && pf_q[0].due == cyc) begin
        exp_pf_v = 1'b1;
        exp_pf_d = pf_q[0].data;
        void'(pf_q.pop_front());
      end
      checks++;
      if (if_rvalid !== exp_if_v) begin
        errors++;
        $display("FAIL sb_if_rvalid cyc=%0d got=%b exp=%b", cyc, if_rvalid, exp_if_v);
      end else if (exp_if_v) begin
        checks++;
        if (if_rdata !== exp_if_d) begin
          errors++;
          $display("FAIL sb_if_rdata cyc=%0d got=%h exp=%h", cyc, if_rdata, exp_if_d);
        end
      end
      checks++;
      if (pf_rvalid !== exp_pf_v) begin
        errors++;
        $display("FAIL sb_pf_rvalid cyc=%0d got=%b exp=%b", cyc, pf_rvalid, exp_pf_v);
      end else if (exp_pf_v) begin
        checks++;
        if (pf_rdata !== exp_pf_d) begin
          errors++;
          $display("FAIL sb_pf_rdata cyc=%0d got=%h exp=%h", cyc, pf_rdata, exp_pf_d);
        end
      end
      last_stall = if_stall;
      last_flush = flush;
      if (flush) begin
        while (if_q.size() > 0 && if_q[0].due == cyc + 1) void'(if_q.pop_front());
        while (pf_q.size() > 0 && pf_q[0].due == cyc + 1) void'(pf_q.pop_front());
      end
    end
  end

  task automatic push_if(input logic [31:0] a);
    if_q.push_back('{due: cyc + 2, data: rom_word(a)});
  endtask

  task automatic push_pf(input logic [31:0] a);
    pf_q.push_back('{due: cyc + 2, data: rom_word(a)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    if_req = 1'b0; pf_req = 1'b0; if_stall = 1'b0; flush = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    idle(0);
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    @(negedge clk);
    checks += 6;
    if (rom_ce !== 1'b0)    begin errors++; $display("FAIL reset_rom_ce got=%b exp=0", rom_ce); end
    if (rom_addr !== '0)    begin errors++; $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); end
    if (if_rvalid !== 1'b0) begin errors++; $display("FAIL reset_if_rvalid got=%b exp=0", if_rvalid); end
    if (pf_rvalid !== 1'b0) begin errors++; $display("FAIL reset_pf_rvalid got=%b exp=0", pf_rvalid); end
    if (if_rdata !== '0)    begin errors++; $display("FAIL reset_if_rdata got=%h exp=0", if_rdata); end
    if (pf_rdata !== '0)    begin errors++; $display("FAIL reset_pf_rdata got=%h exp=0", pf_rdata); end
    step();
    rst = 1'b1;
    idle(1);
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1) begin errors++; $display("FAIL rmr_if_gnt got=%b exp=1", if_gnt); end
    push_if(if_addr);
    step();
    if_req = 1'b0;
    checks++;
    if (rom_ce !== 1'b1) begin errors++; $display("FAIL rmr_issue_ce got=%b exp=1", rom_ce); end
    rst = 1'b0;
    #1;
    checks += 2;
    if (rom_ce !== 1'b0)  begin errors++; $display("FAIL rmr_async_ce got=%b exp=0", rom_ce); end
    if (rom_addr !== '0)  begin errors++; $display("FAIL rmr_async_addr got=%h exp=0", rom_addr); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (if_rvalid !== 1'b0) begin errors++; $display("FAIL rmr_if_rvalid got=%b exp=0", if_rvalid); end
      step();
    end
    rst = 1'b1;
    idle(3);
  endtask

  task automatic test_if_only();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if_req  = (k < 3);
      if_addr = 32'(4 * k);
      @(negedge clk);
      checks += 2;
      if (if_gnt !== (k < 3)) begin errors++; $display("FAIL ifo_if_gnt k=%0d got=%b exp=%b", k, if_gnt, k < 3); end
      if (pf_gnt !== 1'b0)    begin errors++; $display("FAIL ifo_pf_gnt k=%0d got=%b exp=0", k, pf_gnt); end
      if (k < 3) push_if(if_addr);
      if (k >= 1) begin
        checks++;
        if (rom_ce !== (k <= 3)) begin errors++; $display("FAIL ifo_rom_ce k=%0d got=%b exp=%b", k, rom_ce, k <= 3); end
        if (k <= 3) begin
          checks++;
          if (rom_addr !== 32'(4 * (k - 1))) begin
            errors++; $display("FAIL ifo_rom_addr k=%0d got=%h exp=%h", k, rom_addr, 32'(4 * (k - 1)));
          end
        end
      end
      step();
    end
    idle(3);
  endtask

  task automatic test_contention();
    logic exp_pf;
    do_reset();
    if_req = 1'b1; pf_req = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if_addr = 32'h300 + 32'(4 * k);
      pf_addr = 32'h400 + 32'(4 * k);
      exp_pf  = (k % 5 == 4);
      @(negedge clk);
      checks += 2;
      if (pf_gnt !== exp_pf)  begin errors++; $display("FAIL cont_pf_gnt k=%0d got=%b exp=%b", k, pf_gnt, exp_pf); end
      if (if_gnt !== !exp_pf) begin errors++; $display("FAIL cont_if_gnt k=%0d got=%b exp=%b", k, if_gnt, !exp_pf); end
      if (exp_pf) push_pf(pf_addr); else push_if(if_addr);
      step();
    end
    idle(3);
  endtask

  task automatic test_stall();
    do_reset();
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1) begin errors++; $display("FAIL stall_first_gnt got=%b exp=1", if_gnt); end
    push_if(if_addr);
    step();
    if_req = 1'b0;
    step();
    for (int k = 2; k < 5; k++) begin
      if_req = 1'b1; if_addr = 32'h14; if_stall = 1'b1;
      pf_req = (k == 3); pf_addr = 32'h500;
      @(negedge clk);
      checks += 4;
      if (if_gnt !== 1'b0)     begin errors++; $display("FAIL stall_if_gnt k=%0d got=%b exp=0", k, if_gnt); end
      if (pf_gnt !== (k == 3)) begin errors++; $display("FAIL stall_pf_gnt k=%0d got=%b exp=%b", k, pf_gnt, k == 3); end
      if (if_rvalid !== 1'b1)  begin errors++; $display("FAIL stall_hold_v k=%0d got=%b exp=1", k, if_rvalid); end
      if (if_rdata !== rom_word(32'h10)) begin
        errors++; $display("FAIL stall_hold_d k=%0d got=%h exp=%h", k, if_rdata, rom_word(32'h10));
      end
      if (k == 3) push_pf(pf_addr);
      step();
    end
    idle(4);
  endtask

  task automatic test_flush();
    do_reset();
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1) begin errors++; $display("FAIL flush_pre_gnt got=%b exp=1", if_gnt); end
    push_if(if_addr);
    step();
    flush = 1'b1; if_addr = 32'h44; pf_req = 1'b1; pf_addr = 32'h600;
    @(negedge clk);
    checks += 2;
    if (if_gnt !== 1'b0) begin errors++; $display("FAIL flush_if_gnt got=%b exp=0", if_gnt); end
    if (pf_gnt !== 1'b0) begin errors++; $display("FAIL flush_pf_gnt got=%b exp=0", pf_gnt); end
    step();
    idle(0);
    @(negedge clk);
    checks += 2;
    if (rom_ce !== 1'b0)    begin errors++; $display("FAIL flush_rom_ce got=%b exp=0", rom_ce); end
    if (if_rvalid !== 1'b0) begin errors++; $display("FAIL flush_if_rvalid got=%b exp=0", if_rvalid); end
    step();
    idle(3);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if_req  = (k % 2 == 0); if_addr = 32'h700 + 32'(4 * k);
      pf_req  = (k % 2 == 1); pf_addr = 32'h800 + 32'(4 * k);
      @(negedge clk);
      checks += 2;
      if (if_gnt !== (k % 2 == 0)) begin errors++; $display("FAIL b2b_if_gnt k=%0d got=%b", k, if_gnt); end
      if (pf_gnt !== (k % 2 == 1)) begin errors++; $display("FAIL b2b_pf_gnt k=%0d got=%b", k, pf_gnt); end
      if (k % 2 == 0) push_if(if_addr); else push_pf(pf_addr);
      if (k >= 1) begin
        checks++;
        if (rom_ce !== 1'b1) begin errors++; $display("FAIL b2b_rom_ce k=%0d got=%b exp=1", k, rom_ce); end
      end
      step();
    end
    idle(3);
  endtask

  task automatic test_pf_buf();
    logic [31:0] exp_addr;
    do_reset();
    pf_req = 1'b1; pf_addr = 32'h80;
    @(negedge clk);
    checks++;
    if (pf_gnt !== 1'b1) begin errors++; $display("FAIL buf_pf_gnt got=%b exp=1", pf_gnt); end
    push_pf(pf_addr);
    step();
    idle(2);
    if_req = 1'b1; if_addr = 32'h80; pf_req = 1'b1; pf_addr = 32'h84;
    @(negedge clk);
    checks += 2;
    if (if_gnt !== 1'b1) begin errors++; $display("FAIL buf_if_gnt got=%b exp=1", if_gnt); end
`ifdef FETCH_PF_BUF_EN
    if (pf_gnt !== 1'b1) begin errors++; $display("FAIL buf_pf_gnt2 got=%b exp=1", pf_gnt); end
    push_pf(pf_addr);
    exp_addr = 32'h84;
`else
    if (pf_gnt !== 1'b0) begin errors++; $display("FAIL buf_pf_gnt2 got=%b exp=0", pf_gnt); end
    exp_addr = 32'h80;
`endif
    push_if(if_addr);
    step();
    idle(0);
    @(negedge clk);
    checks += 2;
    if (rom_ce !== 1'b1)      begin errors++; $display("FAIL buf_rom_ce got=%b exp=1", rom_ce); end
    if (rom_addr !== exp_addr) begin errors++; $display("FAIL buf_rom_addr got=%h exp=%h", rom_addr, exp_addr); end
    step();
    idle(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_mid_read();
    test_if_only();
    test_contention();
    test_stall();
    test_flush();
    test_back_to_back();
    test_pf_buf();
    checks++;
    if (if_q.size() != 0 || pf_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got=%0d/%0d exp=0/0", if_q.size(), pf_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
